ssd_display_arbiter: RTL

Shares the single 8-digit seven-segment display between several requesters that each want to show a 32-bit hex value. It grants ownership round-robin and holds each grant for a minimum visible time. It forwards the owner's value as the `encoded` input of the display driver. It sits directly upstream of `seven_segment`, which keeps its own digit multiplexing.

---
 rtl/ssd_pkg.sv | 13 +
 rtl/ssd_rr_pick.sv | 27 ++
 rtl/ssd_display_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and state type for the seven-segment display arbiter
package ssd_pkg;

  localparam int SSD_DATA_W  = 32;
  localparam int SSD_DIGITS  = 8;
  localparam int SSD_DIGIT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } ssd_arb_state_t;

endpackage

// File: rtl/ssd_rr_pick.sv
// rtl/ssd_rr_pick.sv - combinational round-robin picker scanning from last+1 upward
module ssd_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [IW-1:0]      win
);

  // First set bit at last+1, last+2, ... wrapping modulo NUM_REQ; last itself is visited last
  always_comb begin
    logic [IW-1:0] cand;
    valid = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// rtl/ssd_display_arbiter.sv - round-robin owner of the 8-digit display with minimum hold time; optional SSD_ARB_PRIORITY_EN makes requester 0 preemptive
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*SSD_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [SSD_DATA_W-1:0]         encoded
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  ssd_arb_state_t  state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   last;
  logic [SSD_DATA_W-1:0] data_arr [NUM_REQ];

  logic [NUM_REQ-1:0] pick_req;
  logic               pick_valid;
  logic [IW-1:0]      pick_win;
  logic               expired;
  logic               preempt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*SSD_DATA_W +: SSD_DATA_W];
  end

  // The current owner never competes against itself at handover
  assign pick_req = req & ~grant;
  assign expired  = (cnt == CNT_MAX);

  ssd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (pick_req),
    .last  (last),
    .valid (pick_valid),
    .win   (pick_win)
  );

`ifdef SSD_ARB_PRIORITY_EN
  logic req0_q;

  // Remember req[0] so only its rising edge preempts a running grant
  always_ff @(posedge Clk) begin
    if (Reset) req0_q <= 1'b0;
    else       req0_q <= req[0];
  end

  // Urgent requester 0 takes the display from any other owner
  always_comb begin
    preempt = (state == HOLD) && req[0] && !req0_q && !grant[0];
  end
`else
  // Pure round-robin build: no preemption path
  always_comb begin
    preempt = 1'b0;
  end
`endif

  // Arbitration FSM with registered grant/owner/busy/encoded
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= IW'(NUM_REQ - 1);
      grant   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      encoded <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state   <= HOLD;
            grant   <= NUM_REQ'(1) << pick_win;
            owner   <= pick_win;
            busy    <= 1'b1;
            last    <= pick_win;
            cnt     <= '0;
            encoded <= data_arr[pick_win];
          end
        end
        HOLD: begin
          if (preempt) begin
            // Round-robin position is left alone so rotation resumes afterwards
            grant   <= NUM_REQ'(1);
            owner   <= '0;
            cnt     <= '0;
            encoded <= data_arr[0];
          end else if (expired && pick_valid) begin
            grant   <= NUM_REQ'(1) << pick_win;
            owner   <= pick_win;
            last    <= pick_win;
            cnt     <= '0;
            encoded <= data_arr[pick_win];
          end else if (expired && !req[owner]) begin
            // encoded and owner keep their values so the display never blanks
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
          end else begin
            if (!expired) cnt <= cnt + CW'(1);
            if (req[owner]) encoded <= data_arr[owner];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
